// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states and the per-stage control bundle.
// The release helper encodes the branch/hazard/idle priority used in RUN and on MEM_WAIT release.
package pipeline_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  typedef struct packed {
    logic freeze_pc;
    logic freeze_if_id;
    logic flush_if_id;
    logic bubble_id_ex;
    logic freeze_id_ex;
    logic freeze_ex_mem;
    logic bubble_mem_wb;
  } stage_ctrl_t;

  localparam int WAIT_CNT_W = 8;

  localparam stage_ctrl_t CTRL_IDLE = '0;

  // Whole pipeline held; MEM/WB gets a bubble so a stalled load never writes back twice.
  localparam stage_ctrl_t CTRL_FREEZE = '{
    freeze_pc:     1'b1,
    freeze_if_id:  1'b1,
    flush_if_id:   1'b0,
    bubble_id_ex:  1'b0,
    freeze_id_ex:  1'b1,
    freeze_ex_mem: 1'b1,
    bubble_mem_wb: 1'b1
  };

  function automatic stage_ctrl_t release_ctrl(input logic branch_taken, input logic hazard);
    stage_ctrl_t c;
    c = CTRL_IDLE;
    if (branch_taken) begin
      c.flush_if_id  = 1'b1;
      c.bubble_id_ex = 1'b1;
    end else if (hazard) begin
      c.freeze_pc    = 1'b1;
      c.freeze_if_id = 1'b1;
      c.bubble_id_ex = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
// One-cycle update latency, no backpressure.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer for the five-stage pipeline: merges hazard, taken branch, SRAM wait and debug halt.
// Stage controls are zero-latency Mealy outputs; counters and the timeout flag update on the next edge.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hazard,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             halt_req,
  input  logic             clr_cnt,
  output logic             freeze_pc,
  output logic             freeze_if_id,
  output logic             flush_if_id,
  output logic             bubble_id_ex,
  output logic             freeze_id_ex,
  output logic             freeze_ex_mem,
  output logic             bubble_mem_wb,
  output logic             halted,
  output logic             mem_timeout_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [WAIT_CNT_W-1:0] WAIT_LAST = WAIT_CNT_W'(MEM_TIMEOUT - 1);

  state_t                state, state_nxt;
  stage_ctrl_t           ctrl;
  logic                  halted_c;
  logic                  halt_pend;
  logic [WAIT_CNT_W-1:0] wait_cnt;
  logic                  mem_stall;

  assign mem_stall = mem_req && !mem_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= RUN;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
        end else if (halt_req) begin
          state_nxt = HALT;
        end
      end
      MEM_WAIT: begin
        if (mem_ready) begin
          state_nxt = (halt_pend || halt_req) ? HALT : RUN;
        end
      end
      HALT: begin
        if (!halt_req) begin
          state_nxt = RUN;
        end
      end
      default: state_nxt = RUN;
    endcase
  end

  // Gated by rst so every control drops the instant reset asserts, not at the next edge.
  always_comb begin
    ctrl     = CTRL_IDLE;
    halted_c = 1'b0;
    if (rst) begin
      case (state)
        RUN: begin
          if (mem_stall || halt_req) begin
            ctrl = CTRL_FREEZE;
          end else begin
            ctrl = release_ctrl(branch_taken, hazard);
          end
        end
        MEM_WAIT: begin
          if (!mem_ready) begin
            ctrl = CTRL_FREEZE;
          end else begin
            ctrl = release_ctrl(branch_taken, hazard);
          end
        end
        HALT: begin
          ctrl     = CTRL_FREEZE;
          halted_c = 1'b1;
        end
        default: ctrl = CTRL_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halt_pend       <= 1'b0;
      wait_cnt        <= '0;
      mem_timeout_err <= 1'b0;
    end else begin
      if (state == MEM_WAIT) begin
        if (mem_ready) begin
          halt_pend <= 1'b0;
        end else if (halt_req) begin
          halt_pend <= 1'b1;
        end
      end else begin
        halt_pend <= 1'b0;
      end

      // The entry cycle in RUN already counts as the first wait cycle.
      if (state == RUN && mem_stall) begin
        wait_cnt <= WAIT_CNT_W'(1);
      end else if (state == MEM_WAIT && !mem_ready && (wait_cnt != '1)) begin
        wait_cnt <= wait_cnt + WAIT_CNT_W'(1);
      end

      if (clr_cnt) begin
        mem_timeout_err <= 1'b0;
      end else if (state == MEM_WAIT && !mem_ready && wait_cnt == WAIT_LAST) begin
        mem_timeout_err <= 1'b1;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.freeze_pc),
    .clr   (clr_cnt),
    .count (stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (ctrl.flush_if_id),
    .clr   (clr_cnt),
    .count (flush_cnt)
  );

  assign freeze_pc     = ctrl.freeze_pc;
  assign freeze_if_id  = ctrl.freeze_if_id;
  assign flush_if_id   = ctrl.flush_if_id;
  assign bubble_id_ex  = ctrl.bubble_id_ex;
  assign freeze_id_ex  = ctrl.freeze_id_ex;
  assign freeze_ex_mem = ctrl.freeze_ex_mem;
  assign bubble_mem_wb = ctrl.bubble_mem_wb;
  assign halted        = halted_c;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4 and CNT_W=4.
module tb_pipeline_ctrl;

  localparam int CW = 4;

  // {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_id_ex, freeze_ex_mem, bubble_mem_wb}
  localparam logic [6:0] C_NONE = 7'b0000000;
  localparam logic [6:0] C_HAZ  = 7'b1101000;
  localparam logic [6:0] C_BR   = 7'b0011000;
  localparam logic [6:0] C_FRZ  = 7'b1100111;

  logic          clk;
  logic          rst;
  logic          hazard, branch_taken, mem_req, mem_ready, halt_req, clr_cnt;
  logic          freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex;
  logic          freeze_id_ex, freeze_ex_mem, bubble_mem_wb;
  logic          halted, mem_timeout_err;
  logic [CW-1:0] stall_cnt, flush_cnt;
  logic [6:0]    ctrl_v;

  int vectors;
  int miscompares;

  pipeline_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst             (rst),
    .hazard          (hazard),
    .branch_taken    (branch_taken),
    .mem_req         (mem_req),
    .mem_ready       (mem_ready),
    .halt_req        (halt_req),
    .clr_cnt         (clr_cnt),
    .freeze_pc       (freeze_pc),
    .freeze_if_id    (freeze_if_id),
    .flush_if_id     (flush_if_id),
    .bubble_id_ex    (bubble_id_ex),
    .freeze_id_ex    (freeze_id_ex),
    .freeze_ex_mem   (freeze_ex_mem),
    .bubble_mem_wb   (bubble_mem_wb),
    .halted          (halted),
    .mem_timeout_err (mem_timeout_err),
    .stall_cnt       (stall_cnt),
    .flush_cnt       (flush_cnt)
  );

  assign ctrl_v = {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex,
                   freeze_id_ex, freeze_ex_mem, bubble_mem_wb};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    hazard = 1'b0; branch_taken = 1'b0; mem_req = 1'b0;
    mem_ready = 1'b0; halt_req = 1'b0; clr_cnt = 1'b0;
  endtask

  task automatic clear_counters();
    idle();
    clr_cnt = 1'b1;
    tick();
    clr_cnt = 1'b0;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0;
    idle();
    hazard = 1'b1;
    #2;
    chk("reset_ctrl", 16'(ctrl_v), 16'(C_NONE));
    chk("reset_halted", 16'(halted), 16'd0);
    chk("reset_stall", 16'(stall_cnt), 16'd0);
    chk("reset_flush", 16'(flush_cnt), 16'd0);
    chk("reset_err", 16'(mem_timeout_err), 16'd0);
    tick();
    rst = 1'b1;
    hazard = 1'b0;
    #1;
    chk("idle_ctrl", 16'(ctrl_v), 16'(C_NONE));

    // Hazard alone
    hazard = 1'b1;
    #1;
    chk("haz_ctrl", 16'(ctrl_v), 16'(C_HAZ));
    tick();
    idle();
    #1;
    chk("haz_stall", 16'(stall_cnt), 16'd1);
    chk("haz_after_ctrl", 16'(ctrl_v), 16'(C_NONE));

    // Branch wins over hazard
    branch_taken = 1'b1; hazard = 1'b1;
    #1;
    chk("br_ctrl", 16'(ctrl_v), 16'(C_BR));
    tick();
    idle();
    #1;
    chk("br_flush", 16'(flush_cnt), 16'd1);
    chk("br_stall", 16'(stall_cnt), 16'd1);

    clear_counters();
    chk("clr_stall", 16'(stall_cnt), 16'd0);
    chk("clr_flush", 16'(flush_cnt), 16'd0);

    // Memory wait: 3 frozen cycles then release; branch ignored on entry
    mem_req = 1'b1; branch_taken = 1'b1; hazard = 1'b1;
    #1;
    chk("mw_entry_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    tick();
    branch_taken = 1'b0; hazard = 1'b0;
    #1;
    chk("mw_1_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    tick();
    chk("mw_2_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    tick();
    mem_ready = 1'b1;
    #1;
    chk("mw_release_ctrl", 16'(ctrl_v), 16'(C_NONE));
    tick();
    idle();
    #1;
    chk("mw_back_run", 16'(ctrl_v), 16'(C_NONE));
    chk("mw_stall", 16'(stall_cnt), 16'd3);
    chk("mw_flush", 16'(flush_cnt), 16'd0);
    chk("mw_err", 16'(mem_timeout_err), 16'd0);

    // Halt held from the 2nd wait cycle, ready on the 4th
    clear_counters();
    mem_req = 1'b1;
    tick();
    tick();
    halt_req = 1'b1;
    tick();
    tick();
    mem_ready = 1'b1;
    #1;
    chk("hmw_release_ctrl", 16'(ctrl_v), 16'(C_NONE));
    chk("hmw_release_halted", 16'(halted), 16'd0);
    tick();
    mem_req = 1'b0; mem_ready = 1'b0;
    #1;
    chk("hmw_halt_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    chk("hmw_halted", 16'(halted), 16'd1);
    tick();
    halt_req = 1'b0; branch_taken = 1'b1;
    #1;
    chk("hmw_drop_halted", 16'(halted), 16'd1);
    chk("hmw_drop_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    tick();
    branch_taken = 1'b0;
    #1;
    chk("hmw_run_halted", 16'(halted), 16'd0);
    chk("hmw_run_ctrl", 16'(ctrl_v), 16'(C_NONE));
    chk("hmw_stall", 16'(stall_cnt), 16'd6);
    chk("hmw_err", 16'(mem_timeout_err), 16'd1);

    // Halt pulse remembered across the wait, hazard on release
    clear_counters();
    chk("clr_err", 16'(mem_timeout_err), 16'd0);
    mem_req = 1'b1;
    tick();
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0; mem_ready = 1'b1; hazard = 1'b1;
    #1;
    chk("pend_release_ctrl", 16'(ctrl_v), 16'(C_HAZ));
    tick();
    idle();
    #1;
    chk("pend_halted", 16'(halted), 16'd1);
    chk("pend_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    tick();
    chk("pend_run_halted", 16'(halted), 16'd0);
    chk("pend_stall", 16'(stall_cnt), 16'd4);
    chk("pend_err", 16'(mem_timeout_err), 16'd0);

    // Timeout after the 4th wait cycle, sticky past ready, clr wins over a stall
    clear_counters();
    mem_req = 1'b1;
    tick();
    tick();
    tick();
    chk("to_err_3", 16'(mem_timeout_err), 16'd0);
    tick();
    chk("to_err_4", 16'(mem_timeout_err), 16'd1);
    mem_ready = 1'b1;
    tick();
    idle();
    tick();
    chk("to_err_sticky", 16'(mem_timeout_err), 16'd1);
    chk("to_stall", 16'(stall_cnt), 16'd4);
    clr_cnt = 1'b1; hazard = 1'b1;
    tick();
    idle();
    #1;
    chk("to_clr_err", 16'(mem_timeout_err), 16'd0);
    chk("to_clr_prio", 16'(stall_cnt), 16'd0);

    // Saturation
    hazard = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    idle();
    chk("sat_stall", 16'(stall_cnt), 16'd15);
    branch_taken = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    idle();
    chk("sat_flush", 16'(flush_cnt), 16'd15);
    chk("sat_stall_hold", 16'(stall_cnt), 16'd15);

    // Reset in the middle of MEM_WAIT with a pending halt
    mem_req = 1'b1;
    tick();
    halt_req = 1'b1;
    tick();
    #1;
    chk("rmw_pre_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    rst = 1'b0;
    #1;
    chk("rmw_ctrl", 16'(ctrl_v), 16'(C_NONE));
    chk("rmw_halted", 16'(halted), 16'd0);
    chk("rmw_stall", 16'(stall_cnt), 16'd0);
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("rmw_run_ctrl", 16'(ctrl_v), 16'(C_NONE));
    tick();
    chk("rmw_no_pend_halt", 16'(halted), 16'd0);

    // Reset in the middle of HALT
    halt_req = 1'b1;
    #1;
    chk("rh_enter_ctrl", 16'(ctrl_v), 16'(C_FRZ));
    tick();
    chk("rh_halted", 16'(halted), 16'd1);
    rst = 1'b0;
    #1;
    chk("rh_rst_halted", 16'(halted), 16'd0);
    chk("rh_rst_ctrl", 16'(ctrl_v), 16'(C_NONE));
    tick();
    idle();
    rst = 1'b1;
    #1;
    chk("rh_run_ctrl", 16'(ctrl_v), 16'(C_NONE));
    chk("rh_run_halted", 16'(halted), 16'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush sequencer for the five-stage ARM pipeline.
- Combines three inputs: the hazard-detect request, the branch-taken signal from EXE, and the multi-cycle SRAM handshake from MEM.
- Produces per-stage freeze/flush/bubble controls. bubble_id_ex is the signal that zeroes ID control outputs.
- Also handles a debug halt and keeps saturating performance counters plus a sticky memory-timeout flag.

Parameters:
- MEM_TIMEOUT, 64: MEM_WAIT cycles without mem_ready before mem_timeout_err sets; range 2..255.
- CNT_W, 16: width of each performance counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- hazard  in  1  RAW hazard from hazard detect (combinational, same cycle).
- branch_taken  in  1  EXE-stage instruction is a taken branch.
- mem_req  in  1  MEM-stage instruction is a load or store (MEM_R_EN | MEM_W_EN).
- mem_ready  in  1  SRAM controller completes the access this cycle.
- halt_req  in  1  debug halt request, level-sensitive.
- clr_cnt  in  1  synchronous clear of the counters and the error flag.
- freeze_pc  out  1  hold PC.
- freeze_if_id  out  1  hold IF/ID register.
- flush_if_id  out  1  load NOP into IF/ID.
- bubble_id_ex  out  1  zero ID control outputs going into ID/EXE.
- freeze_id_ex  out  1  hold ID/EXE register.
- freeze_ex_mem  out  1  hold EXE/MEM register.
- bubble_mem_wb  out  1  zero WB_EN/MEM_R_EN into MEM/WB.
- halted  out  1  pipeline fully frozen by debug halt.
- mem_timeout_err  out  1  sticky error flag.
- stall_cnt  out  CNT_W  cycles with freeze_pc=1.
- flush_cnt  out  CNT_W  taken-branch flushes.

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Reset: state=RUN, all counters 0, mem_timeout_err=0, halt_pend=0, wait_cnt=0.
- Control outputs are Mealy (combinational from state and inputs), zero-latency.
  - Under reset, every control output is 0 and halted=0.
  - Counters and the flag are registered.
- RUN, evaluated in priority order:
  1. mem_req & ~mem_ready:
     - freeze_pc, freeze_if_id, freeze_id_ex, freeze_ex_mem and bubble_mem_wb all =1.
     - Next state MEM_WAIT, wait_cnt<=1.
     - branch_taken and hazard are ignored, because EXE is held and the branch is re-presented later.
  2. halt_req: freeze all four stage registers, bubble_mem_wb=1, next state HALT.
  3. branch_taken: flush_if_id=1, bubble_id_ex=1, PC not frozen (loads target), flush_cnt++. Any simultaneous hazard is ignored.
  4. hazard: freeze_pc=1, freeze_if_id=1, bubble_id_ex=1; later stages advance.
  5. Otherwise all outputs 0.
- MEM_WAIT:
  - halt_req sets halt_pend (registered).
  - mem_ready=0: same freeze set as RUN case 1, wait_cnt++ (saturating at 255). Setting mem_timeout_err <=1 when wait_cnt==MEM_TIMEOUT-1.
  - mem_ready=1:
    - The pipeline releases this cycle. Outputs follow RUN rules 3-5 (branch/hazard evaluated normally; mem_req is already satisfied).
    - Next state is HALT if (halt_pend|halt_req), else RUN. halt_pend clears.
- HALT:
  - All four freezes =1, bubble_mem_wb=1, halted=1.
  - On halt_req=0, return to RUN the next cycle. Outputs are re-evaluated in RUN.
- Counters:
  - stall_cnt increments in every cycle with freeze_pc=1 (hazard, MEM_WAIT entry/wait, halt). Saturates at all-ones.
  - flush_cnt saturates at all-ones.
  - clr_cnt zeroes both counters and mem_timeout_err next edge; clr_cnt takes priority over an increment in the same cycle.
- Reset asserted mid-MEM_WAIT or mid-HALT returns immediately to RUN with outputs 0. The pending halt is discarded.

Decomposition:
- Shared pipeline package holds:
  - the state enum (RUN=2'd0, MEM_WAIT=2'd1, HALT=2'd2);
  - a stage-control bundle typedef {freeze_pc, freeze_if_id, flush_if_id, bubble_id_ex, freeze_id_ex, freeze_ex_mem, bubble_mem_wb}.
- One sub-module, sat_counter (parameter W, inputs inc/clr), instantiated twice.

Test Plan:
- Hazard only: hazard=1 for 1 cycle in RUN -> same cycle freeze_pc=freeze_if_id=bubble_id_ex=1, others 0; stall_cnt 0->1.
- Branch+hazard together: branch_taken=1, hazard=1 -> flush_if_id=bubble_id_ex=1, freeze_pc=0; flush_cnt=1, stall_cnt unchanged.
- Memory wait: mem_req=1, mem_ready=0 for 3 cycles then 1 -> four freezes for 3 cycles, release cycle all 0, state RUN; stall_cnt=3.
- Halt during memory wait: halt_req rises in the 2nd MEM_WAIT cycle, mem_ready on the 4th -> HALT entered after release, halted=1 until halt_req drops, then RUN the next cycle.
- Timeout: MEM_TIMEOUT=4, mem_ready held 0 -> mem_timeout_err=1 after the 4th wait cycle and stays 1 after ready. clr_cnt -> 0.
- Saturation and reset: CNT_W=4, 20 hazard cycles -> stall_cnt=15. Assert rst low in MEM_WAIT -> all outputs 0 immediately, state RUN after release.
